// File: rtl/cell_arb_pkg.sv
// Shared constants for the cell-array write arbiter: FSM encoding, default widths,
// quadrant codes and a small wrap-around increment helper.
package cell_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  localparam int unsigned DEF_POS_W = 2;
  localparam int unsigned DEF_VAL_W = 16;

  localparam logic [1:0] QUAD_TL = 2'd0;
  localparam logic [1:0] QUAD_BL = 2'd1;
  localparam logic [1:0] QUAD_TR = 2'd2;
  localparam logic [1:0] QUAD_BR = 2'd3;

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/cell_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   index,
  output logic            any
);

  int unsigned    i;
  logic [IW-1:0]  idx;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    i      = 0;
    idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      i = 32'(ptr) + k;
      if (i >= NREQ) i = i - NREQ;
      idx = IW'(i);
      if (!any && req[idx]) begin
        any         = 1'b1;
        onehot[idx] = 1'b1;
        index       = idx;
      end
    end
  end

endmodule

// File: rtl/cell_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the cell-array quadrant write port.
// Optional stall timeout with forced release is enabled by defining CWA_TIMEOUT_EN.
module cell_write_arbiter
  import cell_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned POS_W   = DEF_POS_W,
  parameter int unsigned VAL_W   = DEF_VAL_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*POS_W-1:0] req_pos,
  input  logic [NREQ*VAL_W-1:0] req_val,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       gnt,
  output logic [POS_W-1:0]      pos,
  output logic [VAL_W-1:0]      val,
  output logic                  write_enb,
  output logic                  busy
`ifdef CWA_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  logic            state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic            pick_any;
  logic            xfer;
  logic            xfer_last;
  logic            force_rel;
  logic [POS_W-1:0] own_pos;
  logic [VAL_W-1:0] own_val;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0) begin : g_cfg_check
    $error("cell_write_arbiter: NREQ must be 2..8 and TIMEOUT nonzero");
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_oh),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // gnt is zero outside LOCK, so ready needs no state qualification
  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign xfer_last = |(req_valid & req_last & gnt);

  always_comb begin
    own_pos = '0;
    own_val = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        own_pos = req_pos[i*POS_W +: POS_W];
        own_val = req_val[i*VAL_W +: VAL_W];
      end
    end
  end

`ifdef CWA_TIMEOUT_EN
  localparam int unsigned SW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [SW-1:0] stall_cnt;

  // Release fires on the TIMEOUT-th consecutive stalled LOCK cycle
  assign force_rel = (state == ST_LOCK) && !xfer && (stall_cnt == SW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= force_rel;
      if (state != ST_LOCK || xfer || force_rel) stall_cnt <= '0;
      else                                       stall_cnt <= stall_cnt + SW'(1);
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      write_enb <= 1'b0;
      pos       <= '0;
      val       <= '0;
    end else begin
      write_enb <= xfer;
      if (xfer) begin
        pos <= own_pos;
        val <= own_val;
      end
      if (state == ST_IDLE) begin
        if (pick_any) begin
          gnt   <= pick_oh;
          owner <= pick_idx;
          busy  <= 1'b1;
          state <= ST_LOCK;
        end
      end else begin
        if (xfer_last || force_rel) begin
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= IW'(wrap_inc(32'(owner), NREQ));
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_write_arbiter.sv
// Scoreboard bench for cell_write_arbiter: a transaction-level arbiter model predicts
// grants and writes; a monitor compares DUT outputs every cycle.
module tb_cell_write_arbiter;
  import cell_arb_pkg::*;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned POS_W   = 2;
  localparam int unsigned VAL_W   = 16;
  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    logic [POS_W-1:0] p;
    logic [VAL_W-1:0] v;
    logic             last;
  } word_t;

  typedef struct {
    logic [POS_W-1:0] p;
    logic [VAL_W-1:0] v;
    int               cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*POS_W-1:0] req_pos;
  logic [NREQ*VAL_W-1:0] req_val;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       gnt;
  logic [POS_W-1:0]      pos;
  logic [VAL_W-1:0]      val;
  logic                  write_enb;
  logic                  busy;
`ifdef CWA_TIMEOUT_EN
  logic                  timeout_err;
`endif

  word_t wq[NREQ][$];
  exp_t  sb[$];
  logic [NREQ-1:0] hold;
  int    stall_pct;

  int    m_own  = -1;
  int    m_ptr  = 0;
  int    m_cyc  = 0;
  int    m_stall = 0;
  logic  m_terr = 1'b0;
  logic [POS_W-1:0] m_lp = '0;
  logic [VAL_W-1:0] m_lv = '0;

  int errors   = 0;
  int checks   = 0;
  int n_writes = 0;
  int n_terr   = 0;

  always #5 clk = ~clk;

  cell_write_arbiter #(
    .NREQ    (NREQ),
    .POS_W   (POS_W),
    .VAL_W   (VAL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_pos   (req_pos),
    .req_val   (req_val),
    .req_ready (req_ready),
    .gnt       (gnt),
    .pos       (pos),
    .val       (val),
    .write_enb (write_enb),
    .busy      (busy)
`ifdef CWA_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, m_cyc, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] own_oh();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_own >= 0) r[m_own] = 1'b1;
    return r;
  endfunction

  // Reference model: owner/pointer bookkeeping at transaction level
  always @(posedge clk) begin
    word_t w;
    exp_t  e;
    m_cyc++;
    m_terr = 1'b0;
    if (reset) begin
      m_own   = -1;
      m_ptr   = 0;
      m_stall = 0;
      m_lp    = '0;
      m_lv    = '0;
    end else if (m_own < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_own < 0 && req_valid[(m_ptr + k) % NREQ]) begin
          m_own   = (m_ptr + k) % NREQ;
          m_stall = 0;
        end
      end
    end else if (req_valid[m_own]) begin
      w = wq[m_own].pop_front();
      e.p = w.p;
      e.v = w.v;
      e.cyc = m_cyc;
      sb.push_back(e);
      m_stall = 0;
      if (w.last) begin
        m_ptr = (m_own + 1) % NREQ;
        m_own = -1;
      end
    end
`ifdef CWA_TIMEOUT_EN
    else begin
      m_stall++;
      if (m_stall >= TIMEOUT) begin
        m_terr = 1'b1;
        m_ptr  = (m_own + 1) % NREQ;
        m_own  = -1;
      end
    end
`endif
  end

  // Requester drivers
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (wq[i].size() > 0 && !hold[i] && ($urandom_range(99) >= stall_pct)) begin
        req_valid[i]               = 1'b1;
        req_last[i]                = wq[i][0].last;
        req_pos[i*POS_W +: POS_W]  = wq[i][0].p;
        req_val[i*VAL_W +: VAL_W]  = wq[i][0].v;
      end else begin
        req_valid[i]               = 1'b0;
        req_last[i]                = 1'($urandom_range(1));
        req_pos[i*POS_W +: POS_W]  = POS_W'($urandom_range(3));
        req_val[i*VAL_W +: VAL_W]  = VAL_W'($urandom);
      end
    end
  end

  // Monitor
  initial forever begin
    logic exp_we;
    exp_t e;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(own_oh()));
    chk("req_ready", 32'(req_ready), 32'(own_oh()));
    chk("busy", 32'(busy), 32'(m_own >= 0));
`ifdef CWA_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (timeout_err === 1'b1) n_terr++;
`endif
    exp_we = (sb.size() > 0) && (sb[0].cyc == m_cyc);
    chk("write_enb", 32'(write_enb), 32'(exp_we));
    if (exp_we) begin
      e = sb.pop_front();
      m_lp = e.p;
      m_lv = e.v;
    end
    chk("pos", 32'(pos), 32'(m_lp));
    chk("val", 32'(val), 32'(m_lv));
    if (write_enb === 1'b1) n_writes++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int r, input logic [POS_W-1:0] p, input logic [VAL_W-1:0] v,
                           input logic l);
    word_t w;
    w.p = p;
    w.v = v;
    w.last = l;
    wq[r].push_back(w);
  endtask

  task automatic push_burst(input int r, input int len);
    for (int k = 0; k < len; k++)
      push_word(r, POS_W'($urandom_range(3)), VAL_W'($urandom), k == len - 1);
  endtask

  function automatic logic pending();
    logic p;
    p = (m_own >= 0);
    for (int i = 0; i < NREQ; i++) if (wq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while (pending() && c < budget) begin
      tick(1);
      c++;
    end
    tick(2);
    chk(name, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_qsize(input string name, input int r, input int sz, input int budget);
    int c;
    c = 0;
    while (wq[r].size() != sz && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, 32'(c < budget), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_pos   = '0;
    req_val   = '0;
    hold      = '0;
    stall_pct = 0;

    // T1: reset held with every requester valid
    for (int i = 0; i < NREQ; i++) push_word(i, QUAD_BR, 16'hA5A0 + 16'(i), 1'b1);
    tick(3);
    reset = 1'b0;
    wait_drain("t1_drain", 50);

    // T2: four-word burst from requester 0
    nw = n_writes;
    push_word(0, QUAD_TL, 16'h8000, 1'b0);
    push_word(0, QUAD_BL, 16'h1000, 1'b0);
    push_word(0, QUAD_TR, 16'h0008, 1'b0);
    push_word(0, QUAD_BR, 16'h0001, 1'b1);
    wait_drain("t2_drain", 50);
    chk("t2_writes", 32'(n_writes - nw), 32'd4);

    // T3: three-way contention, then requester 0 re-requests
    for (int i = 0; i < NREQ; i++) push_word(i, POS_W'(i), 16'h3000 + 16'(i), 1'b1);
    wait_qsize("t3_req0_done", 0, 0, 50);
    push_word(0, QUAD_TL, 16'h3330, 1'b1);
    wait_drain("t3_drain", 50);

    // T4: owner stalls five cycles mid-burst
    nw = n_writes;
    push_burst(0, 4);
    wait_qsize("t4_two_sent", 0, 2, 50);
    hold[0] = 1'b1;
    tick(5);
    hold[0] = 1'b0;
    wait_drain("t4_drain", 50);
    chk("t4_writes", 32'(n_writes - nw), 32'd4);

    // T5: reset after the second of four words; no replay afterwards
    push_burst(2, 4);
    wait_qsize("t5_two_sent", 2, 2, 50);
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) wq[i].delete();
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) push_word(i, POS_W'(i), 16'h5500 + 16'(i), 1'b1);
    wait_drain("t5_drain", 50);

`ifdef CWA_TIMEOUT_EN
    // T6: owner stalls past the timeout while another requester waits
    nw = n_terr;
    push_burst(0, 2);
    wait_qsize("t6_first_sent", 0, 1, 50);
    hold[0] = 1'b1;
    push_word(1, QUAD_BR, 16'h6601, 1'b1);
    tick(TIMEOUT + 8);
    hold[0] = 1'b0;
    wait_drain("t6_drain", 80);
    chk("t6_terr_pulses", 32'(n_terr - nw), 32'd1);
`endif

    // Randomized traffic with random stalls
    stall_pct = 25;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (wq[i].size() == 0 && $urandom_range(3) == 0) push_burst(i, $urandom_range(1, 4));
      tick(1);
    end
    wait_drain("rand_drain", 400);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
